bcd_to_binary_seq: RTL



---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_mac.sv | 11 +
 rtl/bcd_to_binary_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion and display path: digit limits,
// FSM encoding and the digit-validity helper.
package bcd_pkg;

  localparam int          NUM_DIGITS = 5;
  localparam logic [3:0]  DIGIT_MAX  = 4'd9;
  localparam logic [16:0] BIN_MAX    = 17'd65535;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // True when any 4-bit field of the packed digit vector is not a decimal digit.
  function automatic logic any_digit_invalid(input logic [NUM_DIGITS*4-1:0] digits);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bad = bad | (digits[i*4 +: 4] > DIGIT_MAX);
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal accumulate step: acc_out = acc_in*10 + digit, kept at 17 bits.
module bcd_digit_mac (
  input  logic [16:0] acc_in_i,
  input  logic [3:0]  digit_i,
  output logic [16:0] acc_out_o
);

  // acc_in never exceeds 9999 here, so the shifted terms cannot lose bits.
  assign acc_out_o = (acc_in_i << 3) + (acc_in_i << 1) + {13'd0, digit_i};

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential five-digit BCD to 16-bit binary converter with saturation,
// digit-error reporting and a one-cycle completion pulse.
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [3:0]  ten_thous_i,
  input  logic [3:0]  thousands_i,
  input  logic [3:0]  hundreds_i,
  input  logic [3:0]  tens_i,
  input  logic [3:0]  ones_i,
  output logic [15:0] numb_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_digit_o,
  output logic        overflow_o
);
  import bcd_pkg::*;

  logic [1:0]                 state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0][3:0] dig_in_s;
  logic [2:0]                 idx_q, idx_d;
  logic [16:0]                acc_q, acc_d;
  logic [16:0]                mac_out_s;
  logic [15:0]                numb_q, numb_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       ovf_q, ovf_d;
  logic                       pend_q, pend_d;

  assign dig_in_s = {ten_thous_i, thousands_i, hundreds_i, tens_i, ones_i};

  bcd_digit_mac u_mac (
    .acc_in_i  (acc_q),
    .digit_i   (dig_q[idx_q]),
    .acc_out_o (mac_out_s)
  );

  // Next-state logic; an invalid digit spends one CONV cycle so done lands one edge after accept.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    numb_d  = numb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dig_d   = dig_in_s;
          acc_d   = 17'd0;
          idx_d   = 3'd4;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          pend_d  = any_digit_invalid(dig_in_s);
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (pend_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          numb_d  = 16'h0000;
          err_d   = 1'b1;
          pend_d  = 1'b0;
        end else begin
          acc_d = mac_out_s;
          if (idx_q == 3'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            if (mac_out_s > BIN_MAX) begin
              numb_d = 16'hFFFF;
              ovf_d  = 1'b1;
            end else begin
              numb_d = mac_out_s[15:0];
              ovf_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dig_q   <= '0;
      idx_q   <= 3'd0;
      acc_q   <= 17'd0;
      numb_q  <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      numb_q  <= numb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  assign numb_o      = numb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_digit_o = err_q;
  assign overflow_o  = ovf_q;

endmodule
